echo_cancel_sequencer: RTL and testbench

Cycle-accurate frame sequencer for the echo-cancellation datapath. It replaces delay-based stimulus sequencing with a synthesizable FSM. Once per sampling frame it pulses the two 16-bit-to-double converters, the adaptive parameter estimator (training phase only), the echo canceller and the double-to-16-bit output converter, waiting on each unit's `ready`. It also owns warm-up staging of the `enable_sampling` lines, the training-phase iteration count, output-source selection and error reporting.

---
 rtl/echo_ctrl_pkg.sv | 34 +++
 rtl/echo_cancel_sequencer_if.sv | 21 ++
 rtl/ready_wait_timer.sv | 28 ++
 rtl/echo_cancel_sequencer.sv | 120 ++++++++++++
 tb/tb_echo_cancel_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/echo_ctrl_pkg.sv
// Shared types and constants for the echo-cancellation frame sequencer.
package echo_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CONV_START   = 3'd1,
    ST_CONV_WAIT    = 3'd2,
    ST_ADAPT_START  = 3'd3,
    ST_ADAPT_WAIT   = 3'd4,
    ST_CANCEL_START = 3'd5,
    ST_CANCEL_WAIT  = 3'd6,
    ST_OUT_START    = 3'd7
  } state_t;

  localparam logic [1:0] STG_CONV   = 2'd0;
  localparam logic [1:0] STG_ADAPT  = 2'd1;
  localparam logic [1:0] STG_CANCEL = 2'd2;

  localparam logic OSEL_ERR   = 1'b0;
  localparam logic OSEL_CLEAN = 1'b1;

  function automatic logic is_wait(state_t s);
    return (s == ST_CONV_WAIT) || (s == ST_ADAPT_WAIT) || (s == ST_CANCEL_WAIT);
  endfunction

  function automatic logic [1:0] stage_of(state_t s);
    case (s)
      ST_CONV_WAIT:  return STG_CONV;
      ST_ADAPT_WAIT: return STG_ADAPT;
      default:       return STG_CANCEL;
    endcase
  endfunction

endpackage

// File: rtl/echo_cancel_sequencer_if.sv
// Start/ready handshake between the sequencer and the datapath units.
interface echo_cancel_sequencer_if;
  logic start_conv;
  logic start_adapt;
  logic start_cancel;
  logic start_out;
  logic ready_sig;
  logic ready_sig_lag;
  logic ready_adapt;
  logic ready_cancel;

  modport master (
    output start_conv, start_adapt, start_cancel, start_out,
    input  ready_sig, ready_sig_lag, ready_adapt, ready_cancel
  );

  modport slave (
    input  start_conv, start_adapt, start_cancel, start_out,
    output ready_sig, ready_sig_lag, ready_adapt, ready_cancel
  );
endinterface

// File: rtl/ready_wait_timer.sv
// Wait-state timer shared by all WAIT states: clears whenever not waiting,
// blanks the first wait cycle against stale ready, and flags the timeout.
module ready_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ready,
  output logic done,
  output logic timeout
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  // cnt holds (wait cycle index - 1); every WAIT is entered from a START
  // state, so the counter is always zero on entry.
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run)
      cnt <= '0;
    else if (cnt != CW'(TIMEOUT_CYCLES))
      cnt <= cnt + CW'(1);
  end

  assign done    = run && (cnt != '0) && ready;
  assign timeout = run && !done && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/echo_cancel_sequencer.sv
// Per-frame sequencer: pulses conv/adapt/cancel/out units in order, waits on
// their ready, and owns warm-up gating, training count and error flags.
module echo_cancel_sequencer
  import echo_ctrl_pkg::*;
#(
  parameter int unsigned WARMUP_CANCEL    = 1,
  parameter int unsigned WARMUP_ADAPT     = 2,
  parameter int unsigned TRAIN_ITERATIONS = 50,
  parameter int unsigned TIMEOUT_CYCLES   = 4095
) (
  input  logic                     clk_operation,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [12:0]              sampling_cycle_counter,
  echo_cancel_sequencer_if.master  hs,
  output logic                     enable_sampling_adapt,
  output logic                     enable_sampling_cancel,
  output logic                     out_sel,
  output logic                     training,
  output logic [31:0]              iteration,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [1:0]               err_stage,
  output logic                     frame_overrun
);

  state_t      state, state_nxt;
  logic [31:0] frames;
  logic        frame_zero, trig;
  logic        wait_run, wait_ready, wait_done, wait_tmo;
  logic        reentry, overrun_set;

  assign frame_zero = (sampling_cycle_counter == 13'd0);
  assign trig       = enable && frame_zero;
  assign wait_run   = is_wait(state);

  always_comb begin
    wait_ready = 1'b0;
    case (state)
      ST_CONV_WAIT:   wait_ready = hs.ready_sig && hs.ready_sig_lag;
      ST_ADAPT_WAIT:  wait_ready = hs.ready_adapt;
      ST_CANCEL_WAIT: wait_ready = hs.ready_cancel;
      default:        wait_ready = 1'b0;
    endcase
  end

  ready_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk_operation),
    .rst     (rst),
    .run     (wait_run),
    .ready   (wait_ready),
    .done    (wait_done),
    .timeout (wait_tmo)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:         if (trig) state_nxt = ST_CONV_START;
      ST_CONV_START:   state_nxt = ST_CONV_WAIT;
      ST_CONV_WAIT:    if (wait_done) state_nxt = training ? ST_ADAPT_START : ST_CANCEL_START;
      ST_ADAPT_START:  state_nxt = ST_ADAPT_WAIT;
      ST_ADAPT_WAIT:   if (wait_done) state_nxt = ST_CANCEL_START;
      ST_CANCEL_START: state_nxt = ST_CANCEL_WAIT;
      ST_CANCEL_WAIT:  if (wait_done) state_nxt = ST_OUT_START;
      ST_OUT_START:    state_nxt = trig ? ST_CONV_START : ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
    // An abandoned frame behaves like a normal return to IDLE, including
    // acceptance of a trigger landing on that same cycle.
    if (wait_tmo) state_nxt = trig ? ST_CONV_START : ST_IDLE;
  end

  // The cycle that hands back to IDLE may take a new trigger without
  // counting it as an overrun.
  assign reentry     = (state == ST_OUT_START) || wait_tmo;
  assign overrun_set = frame_zero && (state != ST_IDLE) && !reentry;

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state         <= ST_IDLE;
      frames        <= '0;
      iteration     <= '0;
      out_sel       <= OSEL_ERR;
      timeout_err   <= 1'b0;
      err_stage     <= STG_CONV;
      frame_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_CANCEL_WAIT && wait_done)
        out_sel <= training ? OSEL_ERR : OSEL_CLEAN;
      if (state == ST_OUT_START) begin
        if (training)
          iteration <= iteration + 32'd1;
        if (frames < 32'(WARMUP_ADAPT))
          frames <= frames + 32'd1;
      end
      if (wait_tmo) begin
        timeout_err <= 1'b1;
        err_stage   <= stage_of(state);
      end
      if (overrun_set)
        frame_overrun <= 1'b1;
    end
  end

  assign training               = (iteration < 32'(TRAIN_ITERATIONS));
  assign busy                   = (state != ST_IDLE);
  assign enable_sampling_cancel = (frames >= 32'(WARMUP_CANCEL));
  assign enable_sampling_adapt  = (frames >= 32'(WARMUP_ADAPT)) && training;

  // Pulses are state-decoded; held off while rst is asserted.
  assign hs.start_conv   = !rst && (state == ST_CONV_START);
  assign hs.start_adapt  = !rst && (state == ST_ADAPT_START);
  assign hs.start_cancel = !rst && (state == ST_CANCEL_START);
  assign hs.start_out    = !rst && (state == ST_OUT_START);

endmodule

// File: tb/tb_echo_cancel_sequencer.sv
// Scoreboard bench: a frame-level timing model predicts every start pulse;
// a monitor pops and compares as pulses appear.
module tb_echo_cancel_sequencer;
  localparam int TO    = 16;
  localparam int TRAIN = 3;
  localparam int WC    = 1;
  localparam int WA    = 2;

  logic        clk_operation = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [12:0] scc = 13'd100;
  logic        enable_sampling_adapt, enable_sampling_cancel, out_sel, training;
  logic [31:0] iteration;
  logic        busy, timeout_err, frame_overrun;
  logic [1:0]  err_stage;

  echo_cancel_sequencer_if hs();

  echo_cancel_sequencer #(
    .WARMUP_CANCEL(WC), .WARMUP_ADAPT(WA),
    .TRAIN_ITERATIONS(TRAIN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .enable                 (enable),
    .sampling_cycle_counter (scc),
    .hs                     (hs),
    .enable_sampling_adapt  (enable_sampling_adapt),
    .enable_sampling_cancel (enable_sampling_cancel),
    .out_sel                (out_sel),
    .training               (training),
    .iteration              (iteration),
    .busy                   (busy),
    .timeout_err            (timeout_err),
    .err_stage              (err_stage),
    .frame_overrun          (frame_overrun)
  );

  always #5 clk_operation = ~clk_operation;

  int cyc = 0;
  always @(posedge clk_operation) cyc <= cyc + 1;

  typedef struct { int kind; int p; logic osel; } exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;

  // frame-level reference model state
  int         m_iter = 0, m_frames = 0;
  logic       m_to = 0, m_ovr = 0, m_osel = 0;
  logic [1:0] m_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unit models: ready stale-high in the first wait cycle, then low until
  // wait cycle k, then high (level) until the next start.
  int k_sig = 1, k_lag = 1, k_ad = 1, k_cx = 1;
  int p_cv = 0, p_ad = 0, p_cx = 0;
  int s_sig = 1, s_lag = 1, s_ad = 1, s_cx = 1;

  function automatic logic rdy(int j, int k);
    return (j <= 1) || (j >= k);
  endfunction

  always @(negedge clk_operation) begin
    if (hs.start_conv)   begin p_cv = cyc; s_sig = k_sig; s_lag = k_lag; end
    if (hs.start_adapt)  begin p_ad = cyc; s_ad = k_ad; end
    if (hs.start_cancel) begin p_cx = cyc; s_cx = k_cx; end
    hs.ready_sig     = rdy(cyc - p_cv, s_sig);
    hs.ready_sig_lag = rdy(cyc - p_cv, s_lag);
    hs.ready_adapt   = rdy(cyc - p_ad, s_ad);
    hs.ready_cancel  = rdy(cyc - p_cx, s_cx);
  end

  logic [3:0] pulses;
  exp_t       mon_e;
  always @(negedge clk_operation) begin
    if (!rst) begin
      pulses = {hs.start_out, hs.start_cancel, hs.start_adapt, hs.start_conv};
      for (int k = 0; k < 4; k++) begin
        if (pulses[k]) begin
          if (sb.size() == 0) check("unexpected_pulse_kind", k, -1);
          else begin
            mon_e = sb.pop_front();
            check("pulse_kind", k, mon_e.kind);
            check("pulse_cycle", cyc, mon_e.p);
            if (k == 3) check("out_sel_at_out", out_sel, mon_e.osel);
          end
        end
      end
    end
  end

  function automatic int wlen(int k);
    return (k < 2) ? 2 : k;
  endfunction

  // Predict one frame triggered in period T from the stage ready latencies.
  task automatic launch(input int T, output int t_last, output int t_cx);
    int t, w;
    logic tr;
    tr = (m_iter < TRAIN);
    t = T + 1;
    t_cx = -1;
    sb.push_back('{0, t, 1'b0});
    w = (wlen(k_sig) > wlen(k_lag)) ? wlen(k_sig) : wlen(k_lag);
    if (w > TO) begin m_to = 1; m_err = 2'd0; t_last = t + TO; return; end
    t = t + 1 + w;
    if (tr) begin
      sb.push_back('{1, t, 1'b0});
      if (wlen(k_ad) > TO) begin m_to = 1; m_err = 2'd1; t_last = t + TO; return; end
      t = t + 1 + wlen(k_ad);
    end
    sb.push_back('{2, t, 1'b0});
    t_cx = t;
    if (wlen(k_cx) > TO) begin m_to = 1; m_err = 2'd2; t_last = t + TO; return; end
    t = t + 1 + wlen(k_cx);
    m_osel = !tr;
    sb.push_back('{3, t, m_osel});
    t_last = t;
    if (tr) m_iter++;
    if (m_frames < WA) m_frames++;
  endtask

  task automatic go_to(input int p);
    while (cyc < p) begin
      @(negedge clk_operation);
      scc = 13'($urandom_range(1, 4999));
    end
  endtask

  task automatic check_status();
    check("busy", busy, 0);
    check("iteration", iteration, m_iter);
    check("training", training, m_iter < TRAIN);
    check("en_cancel", enable_sampling_cancel, m_frames >= WC);
    check("en_adapt", enable_sampling_adapt, (m_frames >= WA) && (m_iter < TRAIN));
    check("timeout_err", timeout_err, m_to);
    check("err_stage", err_stage, m_err);
    check("frame_overrun", frame_overrun, m_ovr);
    check("out_sel", out_sel, m_osel);
    check("pending_pulses", sb.size(), 0);
  endtask

  task automatic set_k(input int a, input int b, input int c, input int d);
    k_sig = a; k_lag = b; k_ad = c; k_cx = d;
  endtask

  function automatic int rk();
    return int'($urandom_range(1, 7));
  endfunction

  task automatic frame(input int a, input int b, input int c, input int d, input bit ovr);
    int T, t_last, t_cx;
    go_to(cyc + 2);
    set_k(a, b, c, d);
    T = cyc;
    scc = 13'd0;
    launch(T, t_last, t_cx);
    if (ovr) begin
      go_to(t_cx + 1);
      scc = 13'd0;
      m_ovr = 1;
    end
    go_to(t_last + 2);
    check_status();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int T, tl, tc, tl2, tc2;
    enable = 1'b1;
    go_to(3);
    check_status();
    check("rst_start_conv", hs.start_conv, 0);
    check("rst_start_out", hs.start_out, 0);
    rst = 1'b0;

    frame(1, 1, 1, 1, 0);                 // all ready: pulses at T+1/4/7/10

    go_to(cyc + 2);                       // enable low: trigger ignored
    enable = 1'b0; scc = 13'd0;
    go_to(cyc + 1);
    enable = 1'b1;
    go_to(cyc + 20);
    check_status();

    frame(rk(), rk(), rk(), rk(), 0);
    frame(rk(), rk(), 1000, rk(), 0);     // adapt timeout during training

    // reset while in ADAPT_WAIT
    go_to(cyc + 2);
    set_k(1, 1, 12, 1);
    T = cyc; scc = 13'd0;
    launch(T, tl, tc);
    go_to(T + 7);
    rst = 1'b1;
    sb.delete();
    m_iter = 0; m_frames = 0; m_to = 0; m_ovr = 0; m_osel = 0; m_err = 0;
    go_to(T + 8);
    check_status();
    check("rst_mid_start_cancel", hs.start_cancel, 0);
    rst = 1'b0;
    go_to(cyc + 30);
    check_status();

    frame(rk(), rk(), rk(), rk(), 0);

    // back-to-back: second trigger lands on the OUT_START cycle
    go_to(cyc + 2);
    set_k(rk(), rk(), rk(), rk());
    T = cyc; scc = 13'd0;
    launch(T, tl, tc);
    go_to(tl);
    set_k(rk(), rk(), rk(), rk());
    scc = 13'd0;
    launch(tl, tl2, tc2);
    go_to(tl2 + 2);
    check_status();

    frame(rk(), rk(), rk(), rk(), 1);     // overrun in CANCEL_WAIT
    frame(rk(), rk(), rk(), 17, 0);       // cancel timeout just past limit
    frame(1000, rk(), rk(), rk(), 0);     // conv timeout overwrites stage
    frame(rk(), rk(), rk(), 16, 0);       // ready on the last allowed cycle
    for (int i = 0; i < 4; i++) frame(rk(), rk(), rk(), rk(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
